// File: rtl/mux4_arb.sv
// rtl/mux4_arb.sv - four-channel round-robin merge with a registered output (MUX4_ARB_FIXED_PRIO_EN selects fixed priority)
module mux4_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       selection,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       free;
    logic       accept;
    logic       grant_any;
    logic [1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;

`ifndef MUX4_ARB_FIXED_PRIO_EN
    logic [1:0] last;
    logic [1:0] cand;
`endif

    // Pick the channel to offer a slot to; depends only on in_valid and the pointer
    always_comb begin
        grant_idx = 2'd0;
        grant_any = 1'b0;
`ifdef MUX4_ARB_FIXED_PRIO_EN
        // Lowest index wins: walk from 3 down so channel 0 overrides
        for (int i = 3; i >= 0; i--) begin
            if (in_valid[i]) begin
                grant_idx = 2'(i);
                grant_any = 1'b1;
            end
        end
`else
        cand = 2'd0;
        // Walk offsets 4..1 from the last winner so the nearest successor overrides
        for (int k = 3; k >= 0; k--) begin
            cand = last + 2'(k + 1);
            if (in_valid[cand]) begin
                grant_idx = cand;
                grant_any = 1'b1;
            end
        end
`endif
    end

    // Route the granted channel's word toward the output register
    always_comb begin
        case (grant_idx)
            2'd0:    grant_data = d0;
            2'd1:    grant_data = d1;
            2'd2:    grant_data = d2;
            default: grant_data = d3;
        endcase
    end

    // State register for the output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: fill on acceptance, drain on consume without refill
    always_comb begin
        next_state = state;
        case (state)
            EMPTY: if (accept) next_state = FULL;
            FULL:  if (out_ready && !accept) next_state = EMPTY;
            default: next_state = EMPTY;
        endcase
    end

    // Output logic: handshake signals derived from state, out_ready and in_valid
    always_comb begin
        out_valid = (state == FULL);
        free      = (state == EMPTY) || out_ready;
        in_ready  = 4'b0000;
        if (!rst && free && grant_any) begin
            in_ready = 4'b0001 << grant_idx;
        end
        accept = |(in_ready & in_valid);
    end

    // Output word register: load on acceptance, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            data      <= '0;
            selection <= 2'b00;
        end else if (accept) begin
            data      <= grant_data;
            selection <= grant_idx;
        end
    end

`ifndef MUX4_ARB_FIXED_PRIO_EN
    // Round-robin pointer: remembers the most recent winner; reset makes channel 0 first
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 2'b11;
        end else if (accept) begin
            last <= grant_idx;
        end
    end
`endif

endmodule

// File: tb/tb_mux4_arb.sv
// tb/tb_mux4_arb.sv - directed self-checking bench for mux4_arb
module tb_mux4_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d0, d1, d2, d3;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [7:0] data;
    logic [1:0] selection;
    logic       out_valid;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    mux4_arb #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .selection (selection),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        d0 = 8'h01; d1 = 8'h02; d2 = 8'h03; d3 = 8'h04;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
        checks++; if (selection !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", selection); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready2 got %b want 0000", in_ready); end
        rst = 1'b0;
        in_valid = 4'b0000;
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 4'b0001;
        d0 = 8'hE7;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL single_in_ready got %b want 0001", in_ready); end
        step();
        checks++; if (data !== 8'hE7) begin errors++; $display("FAIL single_data got %h want e7", data); end
        checks++; if (selection !== 2'd0) begin errors++; $display("FAIL single_sel got %0d want 0", selection); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b want 1", out_valid); end
        in_valid = 4'b0000;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL idle_in_ready got %b want 0000", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_rotate();
        logic [1:0] exp_sel [5];
        logic [7:0] vals [4];
        vals[0] = 8'h10; vals[1] = 8'h21; vals[2] = 8'h32; vals[3] = 8'h43;
`ifdef MUX4_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 5; i++) exp_sel[i] = 2'd0;
`else
        exp_sel[0] = 2'd0; exp_sel[1] = 2'd1; exp_sel[2] = 2'd2; exp_sel[3] = 2'd3; exp_sel[4] = 2'd0;
`endif
        do_reset();
        d0 = vals[0]; d1 = vals[1]; d2 = vals[2]; d3 = vals[3];
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (selection !== exp_sel[i] || out_valid !== 1'b1) begin errors++; $display("FAIL rotate_sel[%0d] got %0d/%b want %0d/1", i, selection, out_valid, exp_sel[i]); end
            checks++; if (data !== vals[exp_sel[i]]) begin errors++; $display("FAIL rotate_data[%0d] got %h want %h", i, data, vals[exp_sel[i]]); end
        end
        in_valid = 4'b0000;
        step();
    endtask

    task automatic test_hold_and_wrap();
        do_reset();
        d1 = 8'hAA;
        in_valid = 4'b0010;
        out_ready = 1'b0;
        step();
        checks++; if (data !== 8'hAA || selection !== 2'd1) begin errors++; $display("FAIL hold_load got %h/%0d want aa/1", data, selection); end
        d2 = 8'h5C;
        in_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL hold_in_ready[%0d] got %b want 0000", i, in_ready); end
            step();
            checks++; if (data !== 8'hAA || selection !== 2'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL hold_data[%0d] got %h/%0d/%b want aa/1/1", i, data, selection, out_valid); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL release_in_ready got %b want 0100", in_ready); end
        step();
        checks++; if (data !== 8'h5C || selection !== 2'd2) begin errors++; $display("FAIL release_data got %h/%0d want 5c/2", data, selection); end
        d0 = 8'h11; d1 = 8'h22;
        in_valid = 4'b0011;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL wrap_in_ready got %b want 0001", in_ready); end
        step();
        checks++; if (data !== 8'h11 || selection !== 2'd0) begin errors++; $display("FAIL wrap_data got %h/%0d want 11/0", data, selection); end
    endtask

    task automatic test_idle_pointer();
        logic [3:0] exp_ready;
        in_valid = 4'b0000;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got %b want 0", out_valid); end
        d0 = 8'h0D; d3 = 8'h3D;
        in_valid = 4'b1001;
`ifdef MUX4_ARB_FIXED_PRIO_EN
        exp_ready = 4'b0001;
`else
        exp_ready = 4'b1000;
`endif
        #1;
        checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL idle_ptr_in_ready got %b want %b", in_ready, exp_ready); end
        step();
        in_valid = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        d3 = 8'h77;
        in_valid = 4'b1000;
        out_ready = 1'b0;
        step();
        checks++; if (selection !== 2'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_load got %0d/%b want 3/1", selection, out_valid); end
        rst = 1'b1;
        in_valid = 4'b1001;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_in_ready got %b want 0000", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0 || data !== 8'h00) begin errors++; $display("FAIL mid_rst_out got %b/%h want 0/00", out_valid, data); end
        rst = 1'b0;
        d0 = 8'h99;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL mid_after_in_ready got %b want 0001", in_ready); end
        step();
        checks++; if (selection !== 2'd0 || data !== 8'h99) begin errors++; $display("FAIL mid_after_data got %0d/%h want 0/99", selection, data); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 4'b0000;
        out_ready = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        test_reset();
        test_single();
        test_rotate();
        test_hold_and_wrap();
        test_idle_pointer();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4_arb.md
MUX4_ARB -- requirements
Module: mux4_arb

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data width of every channel.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have ports d0, d1, d2, d3, input, WIDTH bits each: source channel data.
REQ-005 The module SHALL have port in_valid, input, 4 bits: bit i means di holds a word to transfer.
REQ-006 The module SHALL have port in_ready, output, 4 bits: bit i high means di is accepted this cycle.
REQ-007 The module SHALL have port data, output, WIDTH bits: the registered merged output word.
REQ-008 The module SHALL have port selection, output, 2 bits: index of the channel that supplied data.
REQ-009 The module SHALL have port out_valid, output, 1 bit: data and selection hold a word.
REQ-010 The module SHALL have port out_ready, input, 1 bit: the sink takes the word when out_valid is also high.

Function
REQ-011 The output stage SHALL be a two-state machine: EMPTY (out_valid=0) and FULL (out_valid=1).
- The output is free when the state is EMPTY, or when out_valid and out_ready are both high.
REQ-012 When the output is free and in_valid is nonzero, the block SHALL grant exactly one channel g.
- It SHALL drive in_ready to the one-hot pattern for g only; otherwise in_ready SHALL be 4'b0000.
REQ-013 A channel is accepted when its in_ready and in_valid bits are both high.
- On acceptance: at the next edge data SHALL be dg, selection SHALL be g, and the state SHALL be FULL.
- Latency from acceptance to out_valid SHALL be 1 cycle.
REQ-014 State transitions SHALL be:
- EMPTY->FULL on acceptance.
- FULL->EMPTY when the output is consumed and no channel is accepted.
- FULL->FULL on consume plus simultaneous acceptance, giving one word per cycle throughput.
- FULL->FULL with data and selection held unchanged while out_ready=0.
REQ-015 While out_valid=1 and out_ready=0, data and selection SHALL NOT change.
REQ-016 Arbitration SHALL be round-robin.
- A 2-bit pointer last holds the index of the most recently accepted channel.
- The search order SHALL start at last+1 modulo 4 and wrap from 3 to 0.
- The first channel in that order with in_valid set SHALL be granted.
REQ-017 The pointer last SHALL update only on an acceptance, and only to the accepted index.
REQ-018 If all four channels stay valid, the grants SHALL rotate 0,1,2,3,0,... with no channel starved.
REQ-019 in_ready SHALL depend combinationally on in_valid, out_ready and state, and SHALL NOT depend on the di values.
REQ-020 in_valid=4'b0000 SHALL produce no acceptance; the pointer SHALL be unchanged.

Reset
REQ-021 While rst=1 at a clock edge, the block SHALL set:
- state to EMPTY and out_valid to 0;
- data to 0 and selection to 2'b00;
- last to 2'b11, so that channel 0 has first priority after reset.
REQ-022 While rst=1, in_ready SHALL be 4'b0000 and no word SHALL be accepted.
REQ-023 Reset asserted mid-operation SHALL discard any held output word.
- The first cycle after rst falls SHALL behave as a fresh start with channel 0 first.

Configuration
REQ-024 When macro MUX4_ARB_FIXED_PRIO_EN is defined, arbitration SHALL be fixed priority, d0 highest and d3 lowest.
- In this mode the pointer last SHALL NOT exist and SHALL NOT affect the grant.
REQ-025 When MUX4_ARB_FIXED_PRIO_EN is undefined, round-robin per REQ-016 to REQ-018 SHALL apply.
- All other requirements SHALL hold identically in both builds.

Verification
REQ-026 Reset, then in_valid=4'b0001, d0=8'hE7, out_ready=1 -> in_ready=4'b0001; next cycle data=8'hE7, selection=0, out_valid=1.
REQ-027 in_valid=4'b1111 held, d0..d3=8'h10,8'h21,8'h32,8'h43, out_ready=1 -> selection sequence 0,1,2,3,0 on consecutive cycles.
- In the MUX4_ARB_FIXED_PRIO_EN build the same stimulus SHALL give selection 0 on every cycle.
REQ-028 FULL with data=8'hAA and out_ready=0 for 3 cycles while in_valid=4'b0100 -> in_ready=0 and data stays 8'hAA.
- When out_ready rises, the next cycle SHALL give data=d2 and selection=2.
REQ-029 Last grant 2, then in_valid=4'b0011 -> channel 0 granted (wrap from 3 to 0), not channel 1.
REQ-030 FULL with selection=3, assert rst for one cycle -> out_valid=0 and data=0.
- Next, in_valid=4'b1001 SHALL grant channel 0.
